// File: rtl/keypoint_collector.sv
// Collects NMS-surviving pixels as {x, y, score} into a FIFO drained over valid/ready.
// Tracks raster position, enforces a per-frame keypoint cap and reports frame/drop status.
module keypoint_collector #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned MAX_KP = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_score,
  input  logic        i_flag,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [7:0]  o_score,
  output logic        o_frame_done,
  output logic [15:0] o_kp_count,
  output logic        o_overflow,
  output logic        o_capped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [11:0]    x_q, y_q;
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q;
  logic [15:0]    kp_count_q;
  logic           overflow_q, capped_q;

  logic        sof_pix, take, last, full, pop, want, under_cap;
  logic        push, drop_full, drop_cap;
  logic [11:0] cur_x, cur_y;
  logic [15:0] kp_base;

  always_comb begin
    sof_pix   = i_valid && i_sof;
    take      = i_valid && (i_sof || (state_q == StRun));
    // A sof pixel is (0,0) and starts a fresh count before its own accept decision.
    cur_x     = i_sof ? 12'd0 : x_q;
    cur_y     = i_sof ? 12'd0 : y_q;
    kp_base   = sof_pix ? 16'd0 : kp_count_q;
    last      = (cur_x == 12'(WIDTH - 1)) && (cur_y == 12'(HEIGHT - 1));
    full      = (count_q == CW'(DEPTH));
    pop       = o_valid && i_ready;
    want      = take && i_flag;
    under_cap = (kp_base < 16'(MAX_KP));
    push      = want && under_cap && (!full || pop);
    drop_full = want && under_cap && full && !pop;
    drop_cap  = want && !under_cap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      kp_count_q <= '0;
      overflow_q <= 1'b0;
      capped_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (take) begin
        if (cur_x == 12'(WIDTH - 1)) begin
          x_q <= 12'd0;
          y_q <= cur_y + 12'd1;
        end else begin
          x_q <= cur_x + 12'd1;
          y_q <= cur_y;
        end
        state_q <= last ? StDone : StRun;
      end else if (state_q == StDone) begin
        state_q <= StIdle;
      end

      kp_count_q <= kp_base + 16'(push);
      overflow_q <= (overflow_q && !sof_pix) || drop_full;
      capped_q   <= (capped_q && !sof_pix) || drop_cap;

      // When full with a pop, the write slot is the head being consumed this cycle.
      if (push) begin
        mem_q[wr_ptr_q] <= {cur_x, cur_y, i_score};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign o_valid      = (count_q != '0);
  assign o_x          = mem_q[rd_ptr_q][31:20];
  assign o_y          = mem_q[rd_ptr_q][19:8];
  assign o_score      = mem_q[rd_ptr_q][7:0];
  assign o_frame_done = (state_q == StDone);
  assign o_kp_count   = kp_count_q;
  assign o_overflow   = overflow_q;
  assign o_capped     = capped_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// Bench for keypoint_collector: directed scenarios plus random traffic, compared every cycle
// against a frame/queue reference model.
module tb_keypoint_collector;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int unsigned D = 4;
  localparam int unsigned MK = 6;

  logic        clk, rst_n;
  logic        i_valid, i_sof, i_flag, i_ready;
  logic [7:0]  i_score;
  logic        o_valid, o_frame_done, o_overflow, o_capped;
  logic [11:0] o_x, o_y;
  logic [7:0]  o_score;
  logic [15:0] o_kp_count;

  keypoint_collector #(.WIDTH(W), .HEIGHT(H), .DEPTH(D), .MAX_KP(MK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_score(i_score),
    .i_flag(i_flag), .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y),
    .o_score(o_score), .o_frame_done(o_frame_done), .o_kp_count(o_kp_count),
    .o_overflow(o_overflow), .o_capped(o_capped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails, popped;

  // Reference model: frame in progress, linear pixel index, keypoint queue.
  bit          m_active, m_done, m_ovf, m_cap;
  int          m_idx, m_kp;
  logic [31:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_ovf = 0; m_cap = 0; m_idx = 0; m_kp = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit v, input bit s, input bit f, input bit [7:0] sc,
                            input bit r);
    bit pop, do_push;
    logic [31:0] ent;
    pop = (m_q.size() != 0) && r;
    do_push = 0;
    m_done = 0;
    if (v && (s || m_active)) begin
      if (s) begin
        m_idx = 0; m_kp = 0; m_ovf = 0; m_cap = 0;
      end
      if (f) begin
        if (m_kp >= MK) m_cap = 1;
        else if (m_q.size() == D && !pop) m_ovf = 1;
        else begin
          do_push = 1;
          ent = {12'(m_idx % W), 12'(m_idx / W), sc};
          m_kp++;
        end
      end
      m_idx++;
      if (m_idx == W * H) begin
        m_active = 0;
        m_done = 1;
      end else begin
        m_active = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(ent);
  endtask

  task automatic check_outputs();
    chk("valid", 32'(o_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("x", 32'(o_x), 32'(m_q[0][31:20]));
      chk("y", 32'(o_y), 32'(m_q[0][19:8]));
      chk("score", 32'(o_score), 32'(m_q[0][7:0]));
    end
    chk("kp_count", 32'(o_kp_count), 32'(m_kp));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("capped", 32'(o_capped), 32'(m_cap));
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_x"}, 32'(o_x), 0);
    chk({tag, "_y"}, 32'(o_y), 0);
    chk({tag, "_score"}, 32'(o_score), 0);
    chk({tag, "_done"}, 32'(o_frame_done), 0);
    chk({tag, "_kp"}, 32'(o_kp_count), 0);
    chk({tag, "_ovf"}, 32'(o_overflow), 0);
    chk({tag, "_cap"}, 32'(o_capped), 0);
  endtask

  // One clock: drive, check pre-edge outputs against model, advance model on the edge.
  task automatic step(input bit v, input bit s, input bit f, input bit [7:0] sc, input bit r);
    i_valid = v; i_sof = s; i_flag = f; i_score = sc; i_ready = r;
    @(negedge clk);
    check_outputs();
    if (o_valid && i_ready) popped++;
    @(posedge clk);
    model_edge(v, s, f, sc, r);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'($urandom), r);
  endtask

  // Pixels 0..n-1 of a frame, sof on pixel 0; mask bit i flags pixel i.
  task automatic run_pixels(input int n, input logic [31:0] mask, input bit gaps, input bit r);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(0, 0, 0, 8'($urandom), r);
      step(1, i == 0, mask[i], 8'($urandom), r);
    end
  endtask

  initial begin
    tests = 0; fails = 0; popped = 0;
    i_valid = 0; i_sof = 0; i_flag = 0; i_score = 0; i_ready = 0;
    model_reset();
    rst_n = 0;
    #12;
    check_zero("reset");
    rst_n = 1;

    // Basic frame: flags at (3,0), (7,1), (0,3).
    popped = 0;
    run_pixels(32, 32'h0100_8008, 0, 1);
    idle(4, 1);
    chk("frame_drained", popped, 3);

    // Same frame with a gap before every pixel.
    popped = 0;
    run_pixels(32, 32'h0100_8008, 1, 1);
    idle(4, 1);
    chk("gap_drained", popped, 3);

    // Overflow: consumer stalled, six flagged pixels into a four-deep FIFO.
    popped = 0;
    run_pixels(32, 32'h0000_003f, 0, 0);
    idle(3, 0);
    chk("ovf_held_kp", 32'(o_kp_count), 4);
    idle(8, 1);
    chk("ovf_drained", popped, 4);

    // Cap: eight flagged pixels, cap of six; next frame clears the sticky state.
    run_pixels(32, 32'h0000_00ff, 0, 1);
    idle(3, 1);
    chk("cap_kp", 32'(o_kp_count), MK);
    run_pixels(1, 32'h0, 0, 1);

    // Restart mid-frame at pixel 10 with entries still queued from the aborted frame.
    run_pixels(10, 32'h0000_0206, 0, 0);
    run_pixels(32, 32'h8000_0011, 0, 1);
    idle(6, 1);

    // Asynchronous reset with three entries queued, then pixels without sof are ignored.
    run_pixels(3, 32'h0000_0007, 0, 0);
    rst_n = 0;
    #1;
    check_zero("midreset");
    model_reset();
    #1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 8'($urandom), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, s, f, r;
      v = $urandom_range(0, 9) < 8;
      s = (!m_active && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
      f = $urandom_range(0, 3) == 0;
      r = $urandom_range(0, 9) < 6;
      step(v, s, f, 8'($urandom), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypoint_collector.md
# keypoint_collector

Downstream consumer of the non-maximum-suppression stage in the feature pipeline. It takes the per-pixel suppressed score/flag stream, tracks the raster coordinate of each pixel, and packs every surviving keypoint as {x, y, score} into a small FIFO. The FIFO is drained by the descriptor/matching stage over a valid/ready handshake. It also enforces a per-frame keypoint cap and reports frame completion and drop status.

## Interface
Parameters:
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- MAX_KP, 500: maximum keypoints accepted per frame; range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  pixel present this cycle.
- i_sof  in  1  first pixel of a frame; meaningful only with i_valid.
- i_score  in  8  suppressed score from NMS.
- i_flag  in  1  keypoint survived NMS.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  consumer accepts head.
- o_x  out  12  keypoint column.
- o_y  out  12  keypoint row.
- o_score  out  8  keypoint score.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is processed.
- o_kp_count  out  16  keypoints accepted into the FIFO in the current or last frame.
- o_overflow  out  1  sticky per frame: at least one keypoint dropped because the FIFO was full.
- o_capped  out  1  sticky per frame: at least one keypoint dropped because of MAX_KP.

## Operation
- State machine:
  - IDLE: ignore all pixels until i_valid and i_sof.
  - RUN: process pixels. The last pixel is x == WIDTH-1 and y == HEIGHT-1.
  - DONE: lasts one cycle, asserts o_frame_done, then returns to IDLE.
- Coordinates: a pixel with i_valid and i_sof is (0,0), from any state.
  - Each subsequent i_valid pixel increments x.
  - At x == WIDTH-1, x wraps to 0 and y increments.
  - Cycles without i_valid do not advance the counters.
- An i_sof arriving while in RUN restarts the frame: counters go to (0,0), o_kp_count and both sticky flags clear, and no o_frame_done is produced for the aborted frame.
- An i_sof pixel clears o_kp_count, o_overflow and o_capped before that pixel's own accept decision.
- Push condition: in RUN, or on the sof pixel, with i_valid, i_flag and o_kp_count < MAX_KP.
  - A push with the FIFO not full, or full with a pop in the same cycle, is accepted: o_kp_count increments.
  - A push with the FIFO full and no pop in the same cycle is dropped: o_overflow sets and o_kp_count is unchanged.
  - A flagged pixel with o_kp_count == MAX_KP is dropped: o_capped sets.
- The FIFO is not flushed by i_sof. Entries from the previous frame keep draining in order.
- Pop: o_valid && i_ready. o_x, o_y and o_score are the FIFO head and stay stable while o_valid && !i_ready.
- Arithmetic: coordinates are unsigned, zero-extended to 12 bits. o_kp_count saturates at MAX_KP.

## Timing
- Reset values: o_valid 0, o_x 0, o_y 0, o_score 0, o_frame_done 0, o_kp_count 0, o_overflow 0, o_capped 0. State is IDLE and the FIFO is empty.
- Reset mid-frame discards FIFO contents and counters immediately.
- Latency:
  - A keypoint pushed at edge t into an empty FIFO gives o_valid high after edge t, i.e. first visible in cycle t+1.
  - o_valid deasserts the cycle after the last entry pops.
- o_frame_done is high for exactly the one cycle after the edge that consumes the last pixel. It is independent of FIFO drain.
- o_kp_count, o_overflow and o_capped update on the same edge as the push decision. They hold their value after o_frame_done until the next i_sof.
- Throughput: one pixel per cycle in; one keypoint per cycle out with i_ready held high.
- A full FIFO with pop and push in the same cycle keeps its occupancy at DEPTH, and no drop is recorded.

## Test plan
- Frame with WIDTH=8, HEIGHT=4, flags at (3,0), (7,1) and (0,3); i_ready held at 1 -> outputs {3,0,s}, {7,1,s}, {0,3,s} in order; o_kp_count=3; o_frame_done pulses once, one cycle after pixel 31.
- Same frame with i_valid gaps every other cycle -> identical coordinates; o_frame_done is delayed accordingly.
- DEPTH=4, i_ready=0, 6 flagged pixels -> 4 entries held with the head stable; o_overflow=1; o_kp_count=4. Then raising i_ready drains exactly 4 entries.
- MAX_KP=2 with 5 flagged pixels -> 2 entries output; o_capped=1; o_kp_count=2. The next i_sof clears o_kp_count, o_overflow and o_capped.
- i_sof reissued at pixel 10 of a frame -> counters restart at (0,0); no o_frame_done for the aborted frame; old FIFO entries still drain.
- i_rst_n asserted with 3 entries queued -> o_valid=0 and all outputs 0 immediately; pixels without i_sof after release are ignored.
